// File: rtl/mioc_bridge.sv
// CPU memory bridge: zero-latency RAM path, registered IO path with an ack handshake.
// Define MIOC_TIMEOUT_EN to add the IO ack timeout counter and busErr reporting.
module mioc_bridge #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  IO_MASK  = ADDR_W'(32'hF000_0000),
    parameter logic [ADDR_W-1:0]  IO_MATCH = ADDR_W'(32'h7000_0000),
    parameter int unsigned        TO_CYC   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memCe,
    input  logic              memWr,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] wtData,
    output logic [DATA_W-1:0] rdData,
    output logic              stall,
    output logic              busErr,
    output logic              ramCe,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWtData,
    input  logic [DATA_W-1:0] ramRdData,
    output logic              ioCe,
    output logic              ioWe,
    output logic [ADDR_W-1:0] ioAddr,
    output logic [DATA_W-1:0] ioWtData,
    input  logic [DATA_W-1:0] ioRdData,
    input  logic              ioAck
);

    typedef enum logic [1:0] {IDLE, IO_REQ, IO_DONE} state_t;

    if (TO_CYC < 1 || TO_CYC > 65535) begin : g_to_range
        $error("mioc_bridge: TO_CYC must be within 1..65535");
    end

    state_t              state_q, state_d;
    logic                ioce_q, ioce_d;
    logic                iowe_q, iowe_d;
    logic [ADDR_W-1:0]   ioaddr_q, ioaddr_d;
    logic [DATA_W-1:0]   iowdata_q, iowdata_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                buserr_q, buserr_d;
    logic                io_hit;
    logic                timeout;

`ifdef MIOC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TO_CYC + 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Last permitted IO_REQ cycle: the counter would reach TO_CYC on this edge.
    assign timeout = (cnt_q == CNT_W'(TO_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign io_hit   = ((memAddr & IO_MASK) == IO_MATCH);
    assign ioCe     = ioce_q;
    assign ioWe     = iowe_q;
    assign ioAddr   = ioaddr_q;
    assign ioWtData = iowdata_q;
    assign busErr   = buserr_q;

    // Next-state, register next values and combinational CPU/RAM outputs.
    always_comb begin
        state_d   = state_q;
        ioce_d    = ioce_q;
        iowe_d    = iowe_q;
        ioaddr_d  = ioaddr_q;
        iowdata_d = iowdata_q;
        rd_d      = rd_q;
        buserr_d  = 1'b0;
`ifdef MIOC_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        ramCe     = 1'b0;
        ramWe     = 1'b0;
        ramAddr   = '0;
        ramWtData = '0;
        rdData    = '0;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                if (memCe && !io_hit) begin
                    ramCe     = 1'b1;
                    ramWe     = memWr;
                    ramAddr   = memAddr;
                    ramWtData = wtData;
                    rdData    = ramRdData;
                end else if (memCe) begin
                    stall     = 1'b1;
                    ioce_d    = 1'b1;
                    iowe_d    = memWr;
                    ioaddr_d  = memAddr;
                    iowdata_d = wtData;
`ifdef MIOC_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                    state_d   = IO_REQ;
                end
            end

            IO_REQ: begin
                stall = 1'b1;
`ifdef MIOC_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // Abort beats ack; ack beats timeout. IO outputs are cleared on every exit.
                if (!memCe || ioAck || timeout) begin
                    ioce_d    = 1'b0;
                    iowe_d    = 1'b0;
                    ioaddr_d  = '0;
                    iowdata_d = '0;
                    if (!memCe) begin
                        state_d = IDLE;
                    end else if (ioAck) begin
                        rd_d    = iowe_q ? '0 : ioRdData;
                        state_d = IO_DONE;
                    end else begin
                        rd_d     = '0;
                        buserr_d = 1'b1;
                        state_d  = IO_DONE;
                    end
                end
            end

            IO_DONE: begin
                if (memCe) begin
                    rdData = rd_q;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and IO output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ioce_q    <= 1'b0;
            iowe_q    <= 1'b0;
            ioaddr_q  <= '0;
            iowdata_q <= '0;
            rd_q      <= '0;
            buserr_q  <= 1'b0;
`ifdef MIOC_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ioce_q    <= ioce_d;
            iowe_q    <= iowe_d;
            ioaddr_q  <= ioaddr_d;
            iowdata_q <= iowdata_d;
            rd_q      <= rd_d;
            buserr_q  <= buserr_d;
`ifdef MIOC_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mioc_bridge.sv
// Self-checking bench for mioc_bridge: RAM path, IO handshake, abort, reset and timeout.
module tb_mioc_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          memCe, memWr;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] wtData, rdData;
    logic          stall, busErr;
    logic          ramCe, ramWe;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWtData, ramRdData;
    logic          ioCe, ioWe;
    logic [AW-1:0] ioAddr;
    logic [DW-1:0] ioWtData, ioRdData;
    logic          ioAck;

    always #5 clk = ~clk;

    mioc_bridge #(
        .ADDR_W(AW), .DATA_W(DW),
        .IO_MASK(32'hF000_0000), .IO_MATCH(32'h7000_0000),
        .TO_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .memCe(memCe), .memWr(memWr), .memAddr(memAddr), .wtData(wtData),
        .rdData(rdData), .stall(stall), .busErr(busErr),
        .ramCe(ramCe), .ramWe(ramWe), .ramAddr(ramAddr), .ramWtData(ramWtData),
        .ramRdData(ramRdData),
        .ioCe(ioCe), .ioWe(ioWe), .ioAddr(ioAddr), .ioWtData(ioWtData),
        .ioRdData(ioRdData), .ioAck(ioAck)
    );

    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
        int            stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IO access; ack_at = IO_REQ cycle carrying ioAck (0 = never ack).
    task automatic io_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input int ack_at, input logic [DW-1:0] rd);
        exp_t e;
        int   stalls;
        bit   done;
        e.rd     = (we || ack_at == 0) ? '0 : rd;
        e.err    = (ack_at == 0);
        e.stalls = (ack_at == 0) ? int'(TO) + 1 : ack_at + 1;
        exp_q.push_back(e);
        memCe = 1'b1; memWr = we; memAddr = addr; wtData = wd;
        ioRdData = 32'hBADB_AD00;
        #1;
        check("idle_stall", stall, 1'b1);
        check("idle_ramce", ramCe, 1'b0);
        stalls = 1;
        done   = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            tick();
            ioAck    = 1'b0;
            ioRdData = 32'hBADB_AD00;
            if (stall) begin
                stalls++;
                check("req_ioce", ioCe, 1'b1);
                check("req_ioaddr", ioAddr, addr);
                check("req_iowe", ioWe, we);
                check("req_iowdata", ioWtData, wd);
                check("req_ramce", ramCe, 1'b0);
                if (cyc == ack_at) begin
                    ioAck    = 1'b1;
                    ioRdData = rd;
                end
            end else begin
                done = 1;
                e = exp_q.pop_front();
                check("done_rddata", rdData, e.rd);
                check("done_buserr", busErr, e.err);
                check("done_stalls", 64'(stalls), 64'(e.stalls));
                check("done_ioce", ioCe, 1'b0);
                check("done_ramce", ramCe, 1'b0);
            end
        end
        if (!done) check("io_done_bound", 1'b0, 1'b1);
        tick();
        memCe = 1'b0;
        #1;
        check("post_buserr", busErr, 1'b0);
        check("post_ioaddr", ioAddr, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; memCe = 1'b0; memWr = 1'b0; memAddr = '0; wtData = '0;
        ramRdData = '0; ioRdData = '0; ioAck = 1'b0;
        #12;
        check("rst_ioce", ioCe, 1'b0);
        check("rst_buserr", busErr, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_rddata", rdData, '0);
        check("rst_ioaddr", ioAddr, '0);
        tick();
        rst = 1'b0;

        // RAM read, zero latency
        memCe = 1'b1; memWr = 1'b0; memAddr = 32'h0000_0010; ramRdData = 32'hDEAD_BEEF;
        #1;
        check("ram_rd_ce", ramCe, 1'b1);
        check("ram_rd_we", ramWe, 1'b0);
        check("ram_rd_addr", ramAddr, 32'h0000_0010);
        check("ram_rd_data", rdData, 32'hDEAD_BEEF);
        check("ram_rd_stall", stall, 1'b0);
        check("ram_rd_ioce", ioCe, 1'b0);

        // RAM write just outside the IO window
        tick();
        memWr = 1'b1; memAddr = 32'h8000_0000; wtData = 32'h0000_00A5;
        #1;
        check("ram_wr_ce", ramCe, 1'b1);
        check("ram_wr_we", ramWe, 1'b1);
        check("ram_wr_addr", ramAddr, 32'h8000_0000);
        check("ram_wr_data", ramWtData, 32'h0000_00A5);
        check("ram_wr_stall", stall, 1'b0);
        tick();
        memCe = 1'b0;
        #1;
        check("nosel_ramce", ramCe, 1'b0);
        check("nosel_rddata", rdData, '0);

        // Stray ack in IDLE must be ignored
        ioAck = 1'b1;
        tick();
        ioAck = 1'b0;
        check("idle_ack_ioce", ioCe, 1'b0);
        check("idle_ack_stall", stall, 1'b0);

        io_access(1'b1, 32'h7000_0004, 32'h0000_0055, 2, 32'h0);
        io_access(1'b0, 32'h7000_0000, 32'h0, 1, 32'h0000_1234);
        io_access(1'b0, 32'h7FFF_FFFC, 32'h0, 3, 32'hCAFE_F00D);

        // Abort by dropping memCe during IO_REQ
        memCe = 1'b1; memWr = 1'b0; memAddr = 32'h7000_0010;
        tick();
        tick();
        check("abort_ioce_pre", ioCe, 1'b1);
        memCe = 1'b0;
        tick();
        check("abort_ioce", ioCe, 1'b0);
        check("abort_buserr", busErr, 1'b0);
        check("abort_stall", stall, 1'b0);
        check("abort_rddata", rdData, '0);
        memCe = 1'b1; memAddr = 32'h0000_0020; ramRdData = 32'h0BAD_CAFE;
        #1;
        check("abort_idle_ramce", ramCe, 1'b1);
        check("abort_idle_rd", rdData, 32'h0BAD_CAFE);

        // Asynchronous reset mid access
        tick();
        memAddr = 32'h7000_0020;
        tick();
        check("rstmid_ioce_pre", ioCe, 1'b1);
        #2;
        rst = 1'b1; memCe = 1'b0;
        #1;
        check("rstmid_ioce", ioCe, 1'b0);
        check("rstmid_ioaddr", ioAddr, '0);
        check("rstmid_buserr", busErr, 1'b0);
        tick();
        rst = 1'b0;
        memCe = 1'b1; memWr = 1'b0; memAddr = 32'h8000_0000; ramRdData = 32'h1111_2222;
        #1;
        check("rstmid_ram_ce", ramCe, 1'b1);
        check("rstmid_ram_stall", stall, 1'b0);
        check("rstmid_ram_rd", rdData, 32'h1111_2222);
        tick();
        memCe = 1'b0;
        io_access(1'b1, 32'h7000_0040, 32'hA5A5_5A5A, 1, 32'h0);

`ifdef MIOC_TIMEOUT_EN
        io_access(1'b0, 32'h7000_0008, 32'h0, 0, 32'h0);
`else
        // Without the timeout the IO request waits until the CPU withdraws
        memCe = 1'b1; memWr = 1'b0; memAddr = 32'h7000_0008;
        for (int i = 0; i < 20; i++) tick();
        check("nto_stall", stall, 1'b1);
        check("nto_ioce", ioCe, 1'b1);
        check("nto_buserr", busErr, 1'b0);
        memCe = 1'b0;
        tick();
        check("nto_abort_ioce", ioCe, 1'b0);
        check("nto_abort_buserr", busErr, 1'b0);
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
